// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encodings and bus widths for the data-memory responder
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between initiator and responder
interface dmem_responder_if;
    import dmem_pkg::*;
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [WORD_W-1:0] ReqAddr;
    logic [WORD_W-1:0] ReqWData;
    logic [LANES-1:0]  ReqByteEn;
    logic              RespValid;
    logic              RespReady;
    logic [WORD_W-1:0] RespRData;
    logic              RespErr;
    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByteEn, RespReady,
        input  ReqReady, RespValid, RespRData, RespErr
    );
    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByteEn, RespReady,
        output ReqReady, RespValid, RespRData, RespErr
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-lane write port, combinational read, cleared on reset
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [LANES-1:0]  be,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    // merge enabled byte lanes of the write data into the addressed word
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < LANES; i++)
            if (we && be[i]) mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
    end

    // storage registers, zeroed by reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) mem_q <= '{default: '0};
        else      mem_q <= mem_d;
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with fixed wait states and error check
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 32
) (
    input  logic             CLK,
    input  logic             RST,
    dmem_responder_if.slave  bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [LANES-1:0]  be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              err;
    logic              access;
    logic [WORD_W-1:0] rdata;

    assign err    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);

    dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .CLK   (CLK),
        .RST   (RST),
        .we    (access && write_q && !err),
        .waddr (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .be    (be_q),
        .raddr (addr_q[AW+1:2]),
        .rdata (rdata)
    );

    // next-state logic: accept in IDLE, count down in WAIT, hold response until taken
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: if (bus.ReqValid && req_ready_q) begin
                write_d     = bus.ReqWrite;
                addr_d      = bus.ReqAddr;
                wdata_d     = bus.ReqWData;
                be_d        = bus.ReqByteEn;
                cnt_d       = 4'(WAIT_CYCLES);
                req_ready_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: if (cnt_q == 4'd0) begin
                resp_valid_d = 1'b1;
                resp_err_d   = err;
                resp_rdata_d = (err || write_q) ? '0 : rdata;
                state_d      = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (bus.RespReady) begin
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // state, request latch and registered outputs; reset aborts any transaction
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.ReqReady  = req_ready_q;
    assign bus.RespValid = resp_valid_q;
    assign bus.RespRData = resp_rdata_q;
    assign bus.RespErr   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus hand sequences for hold, reset and zero-wait streaming
module tb_dmem_responder;
    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    dmem_responder_if bus();
    dmem_responder_if bus0();

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(32)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int n;
        @(negedge CLK);
        bus.ReqWrite  = w;
        bus.ReqAddr   = addr;
        bus.ReqWData  = wd;
        bus.ReqByteEn = be;
        bus.ReqValid  = 1'b1;
        bus.RespReady = 1'b0;
        n = 0;
        while (!bus.ReqReady && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n == 20) chk("issue_ready_timeout", 32'(bus.ReqReady), 32'd1);
        @(posedge CLK);
        #1;
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = ~w;
        bus.ReqAddr   = 32'hFFFF_FFFC;
        bus.ReqWData  = $urandom;
        bus.ReqByteEn = 4'hF;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!bus.RespValid && lat < 40);
    endtask

    task automatic finish_resp();
        @(negedge CLK);
        bus.RespReady = 1'b1;
        @(posedge CLK);
        #1;
        bus.RespReady = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic e, output int lat);
        issue(w, addr, wd, be);
        wait_resp(lat);
        rd = bus.RespRData;
        e  = bus.RespErr;
        finish_resp();
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          cnt;
        int          resp_k [$];

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0, 3};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0, 3};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0, 3};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1010, 32'h11BB_33DD, 1'b0, 3};
        vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1, 3};
        vecs[6]  = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1, 3};
        vecs[7]  = '{1'b1, 32'h0000_0006, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b1, 3};
        vecs[8]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b0, 3};
        vecs[9]  = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0, 3};
        vecs[10] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'b0110, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[11] = '{1'b0, 32'h0000_007C, 32'h0000_0000, 4'b0011, 32'h0000_0000, 1'b0, 3};
        vecs[12] = '{1'b1, 32'h0000_007C, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b0, 3};
        vecs[13] = '{1'b0, 32'h0000_007C, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 1'b0, 3};
        vecs[14] = '{1'b1, 32'h1000_0000, 32'h0000_0055, 4'b1111, 32'h0000_0000, 1'b1, 3};

        RST = 1'b0;
        {bus.ReqValid, bus.ReqWrite, bus.ReqAddr, bus.ReqWData, bus.ReqByteEn, bus.RespReady} = '0;
        {bus0.ReqValid, bus0.ReqWrite, bus0.ReqAddr, bus0.ReqWData, bus0.ReqByteEn, bus0.RespReady} = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", 32'(bus.ReqReady), 32'd1);
        chk("rst_resp_valid", 32'(bus.RespValid), 32'd0);
        chk("rst_resp_rdata", bus.RespRData, 32'd0);
        chk("rst_resp_err", 32'(bus.RespErr), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 15; i++) begin
            xact(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, e, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // response held while RespReady stays low; competing request is refused
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        wait_resp(lat);
        chk("hold_lat", 32'(lat), 32'd3);
        @(negedge CLK);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("hold%0d_valid", i), 32'(bus.RespValid), 32'd1);
            chk($sformatf("hold%0d_rdata", i), bus.RespRData, 32'hDEAD_BEEF);
            chk($sformatf("hold%0d_req_ready", i), 32'(bus.ReqReady), 32'd0);
        end
        @(negedge CLK);
        bus.RespReady = 1'b1;
        @(posedge CLK);
        #1;
        bus.RespReady = 1'b0;
        chk("complete_valid", 32'(bus.RespValid), 32'd0);
        chk("complete_no_accept", 32'(bus.ReqReady), 32'd1);
        @(posedge CLK);
        #1;
        chk("next_edge_accept", 32'(bus.ReqReady), 32'd0);
        bus.ReqValid = 1'b0;
        bus.ReqAddr  = 32'h0000_0008;
        wait_resp(lat);
        chk("after_hold_lat", 32'(lat), 32'd3);
        chk("after_hold_rdata", bus.RespRData, 32'h11BB_33DD);
        finish_resp();

        // reset during WAIT of a store aborts it
        issue(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("abort_req_ready", 32'(bus.ReqReady), 32'd1);
        chk("abort_resp_valid", 32'(bus.RespValid), 32'd0);
        chk("abort_resp_rdata", bus.RespRData, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            if (bus.RespValid) cnt++;
        end
        chk("abort_no_resp", 32'(cnt), 32'd0);
        xact(1'b0, 32'h0000_0004, 32'h0, 4'hF, rd, e, lat);
        chk("abort_load04_rdata", rd, 32'd0);
        chk("abort_load04_err", 32'(e), 32'd0);
        xact(1'b0, 32'h0000_0008, 32'h0, 4'hF, rd, e, lat);
        chk("rst_cleared_08", rd, 32'd0);

        // zero-wait responder streaming back-to-back loads
        @(negedge CLK);
        bus0.ReqValid  = 1'b1;
        bus0.ReqWrite  = 1'b0;
        bus0.ReqAddr   = 32'h0;
        bus0.RespReady = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK);
            #1;
            if (bus0.RespValid) resp_k.push_back(k);
        end
        bus0.ReqValid  = 1'b0;
        bus0.RespReady = 1'b0;
        chk("stream_count", 32'(resp_k.size()), 32'd4);
        for (int i = 0; i < resp_k.size() && i < 4; i++)
            chk($sformatf("stream%0d_cycle", i), 32'(resp_k[i]), 32'(2 + 3 * i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
